// File: rtl/rom_16x8_arbiter_if.sv
// Requester and ROM-side bus of the two-port ROM read arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the ROM.
interface rom_16x8_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rd_data;
  logic              grant_id;
  logic              busy;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  req0, addr0, req1, addr1, rom_data,
    output ack0, ack1, rd_data, grant_id, busy, rom_address
  );

  modport master (
    output req0, addr0, req1, addr1, rom_data,
    input  ack0, ack1, rd_data, grant_id, busy, rom_address
  );
endinterface

// File: rtl/rom_16x8_arbiter.sv
// Round-robin arbiter that shares one asynchronous 16x8 ROM between two requesters.
// A read has three phases: grant and latch the address, one settle cycle, then registered data with an ack pulse.
module rom_16x8_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rom_16x8_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              winner;

  always_comb begin
    // NOTE: every variable gets its hold value first so that no path through the case infers a latch.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    rom_address_d = rom_address_q;
    rd_data_d     = rd_data_q;
    ack0_d        = ack0_q;
    ack1_d        = ack1_q;
    winner        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Under contention the requester that was not served last wins.
          winner        = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
          grant_id_d    = winner;
          rom_address_d = winner ? bus.addr1 : bus.addr0;
          state_d       = READ;
        end
      end
      READ: begin
        rd_data_d = bus.rom_data;
        ack0_d    = ~grant_id_q;
        ack1_d    = grant_id_q;
        state_d   = RESP;
      end
      RESP: begin
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_id_q    <= 1'b0;
      rom_address_q <= '0;
      rd_data_q     <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      rom_address_q <= rom_address_d;
      rd_data_q     <= rd_data_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.rom_address = rom_address_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/rom_16x8_arbiter.md
Name: rom_16x8_arbiter

Overview:
- Two-port read arbiter that shares one rom_16x8_async instance between two requesters.
- Round-robin grant, latched address, one-cycle settle for the asynchronous ROM read, then registered data with a one-cycle acknowledge pulse.
- Sits between the ROM and its consumers, for example two lookup engines.

Parameters:
ADDR_W, 4, ROM address width (16 words).
DATA_W, 8, ROM data width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
req0  input  1  requester 0 read request (level).
addr0  input  ADDR_W  requester 0 address, valid while req0=1.
req1  input  1  requester 1 read request (level).
addr1  input  ADDR_W  requester 1 address, valid while req1=1.
ack0  output  1  one-cycle pulse: rd_data valid for requester 0.
ack1  output  1  one-cycle pulse: rd_data valid for requester 1.
rd_data  output  DATA_W  registered read data; holds until the next capture.
grant_id  output  1  requester currently or last served.
busy  output  1  high in READ and RESP states.
rom_address  output  ADDR_W  registered address driven to ROM address.
rom_data  input  DATA_W  from ROM data_out (asynchronous).

Behaviour:
- Reset (rst=1 at posedge), regardless of state:
  - state=IDLE.
  - ack0=ack1=0, rd_data=0, rom_address=0, grant_id=0, busy=0.
  - last_grant=1, so requester 0 wins the first contention.
  - A transaction in flight when rst is asserted is aborted; no ack is issued.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - No request: stay in IDLE; all outputs hold.
  - Only req0: grant 0. Only req1: grant 1.
  - Both: grant the requester opposite to last_grant.
  - On grant: rom_address <= winner's addr, grant_id <= winner, go to READ.
- READ, exactly one cycle:
  - ROM settles; rom_address is stable.
  - At the end of the cycle: rd_data <= rom_data, ack of the winner <= 1, go to RESP.
- RESP, exactly one cycle:
  - Winner's ack=1; the other ack=0.
  - At the end: ack <= 0, last_grant <= grant_id, go to IDLE.
- Latency: req sampled at posedge N (in IDLE) gives ack high in cycle N+2 to N+3 and rd_data valid from the same edge.
- Throughput: one read per 3 cycles. With both requesting continuously, grants alternate 0,1,0,1,...
- Handshake:
  - A requester holds req and addr stable until its ack.
  - It must drop req in the cycle after ack, i.e. the IDLE cycle. If req is still 1 at that IDLE edge, it is a new request.
  - addr changes while not granted are ignored; the address is latched only at grant.
  - req dropped before ack: the transaction still completes and ack still pulses.
- rd_data and rom_address are not cleared between transactions.
- ack0 and ack1 are never high simultaneously. busy=0 only in IDLE.
- Width rules: addresses pass through unmodified, with no wrap logic; address 15 is a normal access.

Test Plan:
- Reset: rst=1 for 2 cycles with req0=req1=1 -> ack0=ack1=0, rd_data=00, rom_address=0, busy=0. After release the first grant goes to requester 0.
- Single requester sweep: req0 with addr0=0..15 sequentially, honouring the handshake -> each ack0 arrives 2 edges after the request edge, rd_data = addr times 0x11 (00,11,...,FF), ack1 never asserted.
- Contention: req0 (addr0=3) and req1 (addr1=12) both held -> ack0 with 33 first, then ack1 with CC, then ack0 again. Strict alternation over 8 reads, 3-cycle spacing.
- Fairness after an idle period: requester 1 served last; later both raise req at the same edge -> requester 0 granted. Repeat with 0 served last -> requester 1 granted.
- Address change while waiting: req1 pending with addr1=5 while requester 0 is served; change addr1 to 9 before grant -> ack1 returns 99. Change addr1 after grant (in READ) -> still the latched value.
- Reset mid-operation: assert rst during READ for req0 addr=7 -> no ack0, state returns to IDLE, rd_data=00. A fresh request afterwards returns 77 normally.
